mc_arb_a_rr_faw: RTL and testbench

- Parametrised activate-command arbiter for the DDR4 memory controller; successor to the fixed 4-group activate arbiter.
- Grants one activate per cycle among NGROUPS group FSMs using a single rotating round-robin pointer.
- New versus the 4-group arbiter: per-rank tRRD spacing and tFAW four-activate-window gating are applied before arbitration, so a request to a blocked rank is never granted.
- Sits between the group FSMs' activate requests and the command mux.

---
 rtl/mc_arb_a_rr_faw_if.sv | 35 +++
 rtl/mc_arb_a_rr_faw.sv | 162 ++++++++++++++++
 tb/tb_mc_arb_a_rr_faw.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_arb_a_rr_faw_if.sv
// Activate-request bundle between the group FSMs and the activate arbiter.
// The group side drives req/cmdRank; the arbiter returns the grant and rank status.
interface mc_arb_a_rr_faw_if #(
  parameter int NGROUPS   = 4,
  parameter int RKBITS    = 2,
  parameter int RANK_SLAB = 4
);
  logic [NGROUPS-1:0]        req;
  logic [RKBITS*NGROUPS-1:0] cmdRank;
  logic                      winAct;
  logic [NGROUPS-1:0]        winPort;
  logic [NGROUPS-1:0]        act_winPort_nxt;
  logic [RANK_SLAB-1:0]      act_rank_update;
  logic [RANK_SLAB-1:0]      rank_blocked;

  modport master (
    output req,
    output cmdRank,
    input  winAct,
    input  winPort,
    input  act_winPort_nxt,
    input  act_rank_update,
    input  rank_blocked
  );

  modport slave (
    input  req,
    input  cmdRank,
    output winAct,
    output winPort,
    output act_winPort_nxt,
    output act_rank_update,
    output rank_blocked
  );
endinterface

// File: rtl/mc_arb_a_rr_faw.sv
// Round-robin activate arbiter with per-rank tRRD spacing and tFAW window gating.
// Blocked ranks are masked out before arbitration, so a grant always goes to a legal rank.
module mc_arb_a_rr_faw #(
  parameter real TCQ       = 0.1,
  parameter int  NGROUPS   = 4,
  parameter int  RKBITS    = 2,
  parameter int  RANK_SLAB = 4,
  parameter int  TRRD      = 4,
  parameter int  TFAW      = 16
) (
  input logic              clk,
  input logic              rst,
  mc_arb_a_rr_faw_if.slave arb
);
  localparam int PTR_W       = $clog2(NGROUPS);
  localparam int RRD_W       = $clog2(TRRD) + 1;
  localparam int FAW_W       = $clog2(TFAW) + 1;
  localparam int NSLOT       = 4;
  localparam int NRANK_CODES = 2 ** RKBITS;

  if (NGROUPS < 2 || NGROUPS > 16 || RANK_SLAB < 1 || RANK_SLAB > NRANK_CODES ||
      TRRD < 1 || TFAW < TRRD || TCQ < 0.0) begin : g_bad_param
    $error("mc_arb_a_rr_faw: illegal parameter combination");
  end

  logic [PTR_W-1:0]       ptr_reg;
  logic [PTR_W-1:0]       ptr_next;
  logic                   win_act_reg;
  logic [NGROUPS-1:0]     win_port_reg;

  logic [RKBITS-1:0]      rank_of [NGROUPS];
  logic [RANK_SLAB-1:0]   rank_blocked;
  logic [NRANK_CODES-1:0] code_blocked;
  logic [NGROUPS-1:0]     eligible;
  logic [RANK_SLAB-1:0]   rank_grant;

  logic [NGROUPS-1:0]     win_onehot;
  logic [PTR_W-1:0]       win_idx;
  logic [RKBITS-1:0]      win_rank;
  logic                   win_found;
  logic [PTR_W:0]         scan_sum;
  logic [PTR_W-1:0]       scan_idx;

  // Rank codes beyond the tracked slab are permanently blocked, so such requests stall.
  for (genvar gi = 0; gi < NRANK_CODES; gi++) begin : g_code
    if (gi < RANK_SLAB) begin : g_tracked
      assign code_blocked[gi] = rank_blocked[gi];
    end else begin : g_untracked
      assign code_blocked[gi] = 1'b1;
    end
  end

  for (genvar gi = 0; gi < NGROUPS; gi++) begin : g_group
    assign rank_of[gi]  = arb.cmdRank[RKBITS*gi +: RKBITS];
    assign eligible[gi] = arb.req[gi] & ~code_blocked[rank_of[gi]];
  end

  // Scan ptr, ptr+1, ... modulo NGROUPS; the first eligible index wins.
  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    win_rank   = '0;
    win_found  = 1'b0;
    scan_sum   = '0;
    scan_idx   = '0;
    for (int k = 0; k < NGROUPS; k++) begin
      scan_sum = {1'b0, ptr_reg} + (PTR_W+1)'(k);
      if (scan_sum >= (PTR_W+1)'(NGROUPS)) begin
        scan_sum = scan_sum - (PTR_W+1)'(NGROUPS);
      end
      scan_idx = scan_sum[PTR_W-1:0];
      if (!win_found && eligible[scan_idx]) begin
        win_found            = 1'b1;
        win_idx              = scan_idx;
        win_rank             = rank_of[scan_idx];
        win_onehot[scan_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (win_found) begin
      if (win_idx == PTR_W'(NGROUPS - 1)) begin
        ptr_next = '0;
      end else begin
        ptr_next = win_idx + PTR_W'(1);
      end
    end
  end

  for (genvar gi = 0; gi < RANK_SLAB; gi++) begin : g_rank_grant
    assign rank_grant[gi] = win_found & (win_rank == RKBITS'(gi));
  end

  // Per-rank timing state: one tRRD down-counter and four tFAW window slots.
  for (genvar gi = 0; gi < RANK_SLAB; gi++) begin : g_rank
    logic [RRD_W-1:0] rrd_cnt_reg;
    logic [RRD_W-1:0] rrd_cnt_next;
    logic [FAW_W-1:0] faw_cnt_reg  [NSLOT];
    logic [FAW_W-1:0] faw_cnt_next [NSLOT];
    logic             faw_full;
    logic             slot_loaded;

    always_comb begin
      faw_full = 1'b1;
      for (int k = 0; k < NSLOT; k++) begin
        faw_full = faw_full & (faw_cnt_reg[k] != '0);
      end
    end

    assign rank_blocked[gi] = (rrd_cnt_reg != '0) | faw_full;

    // A grant reloads tRRD and claims the lowest idle window slot; all else counts down.
    always_comb begin
      rrd_cnt_next = (rrd_cnt_reg != '0) ? rrd_cnt_reg - RRD_W'(1) : '0;
      if (rank_grant[gi]) begin
        rrd_cnt_next = RRD_W'(TRRD - 1);
      end
      slot_loaded = 1'b0;
      for (int k = 0; k < NSLOT; k++) begin
        faw_cnt_next[k] = (faw_cnt_reg[k] != '0) ? faw_cnt_reg[k] - FAW_W'(1) : '0;
        if (rank_grant[gi] && !slot_loaded && (faw_cnt_reg[k] == '0)) begin
          faw_cnt_next[k] = FAW_W'(TFAW - 1);
          slot_loaded     = 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rrd_cnt_reg <= '0;
        for (int k = 0; k < NSLOT; k++) begin
          faw_cnt_reg[k] <= '0;
        end
      end else begin
        rrd_cnt_reg <= rrd_cnt_next;
        for (int k = 0; k < NSLOT; k++) begin
          faw_cnt_reg[k] <= faw_cnt_next[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg      <= '0;
      win_act_reg  <= 1'b0;
      win_port_reg <= '0;
    end else begin
      ptr_reg      <= ptr_next;
      win_act_reg  <= |eligible;
      win_port_reg <= win_onehot;
    end
  end

  assign arb.winAct          = win_act_reg;
  assign arb.winPort         = win_port_reg;
  assign arb.act_winPort_nxt = win_onehot;
  assign arb.act_rank_update = rank_grant;
  assign arb.rank_blocked    = rank_blocked;
endmodule

// File: tb/tb_mc_arb_a_rr_faw.sv
// Directed bench for mc_arb_a_rr_faw: three instances cover TRRD=4, TRRD=2 and a
// reduced rank slab; every expected value below is hand-derived from the timing rules.
module tb_mc_arb_a_rr_faw;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mc_arb_a_rr_faw_if #(.NGROUPS(4), .RKBITS(2), .RANK_SLAB(4)) ia ();
  mc_arb_a_rr_faw_if #(.NGROUPS(4), .RKBITS(2), .RANK_SLAB(4)) ib ();
  mc_arb_a_rr_faw_if #(.NGROUPS(4), .RKBITS(2), .RANK_SLAB(3)) ic ();

  mc_arb_a_rr_faw #(.NGROUPS(4), .RKBITS(2), .RANK_SLAB(4), .TRRD(4), .TFAW(16))
    dut_a (.clk(clk), .rst(rst), .arb(ia));
  mc_arb_a_rr_faw #(.NGROUPS(4), .RKBITS(2), .RANK_SLAB(4), .TRRD(2), .TFAW(16))
    dut_b (.clk(clk), .rst(rst), .arb(ib));
  mc_arb_a_rr_faw #(.NGROUPS(4), .RKBITS(2), .RANK_SLAB(3), .TRRD(4), .TFAW(16))
    dut_c (.clk(clk), .rst(rst), .arb(ic));

  // Leaves the bench 1 time unit after a rising edge with rst low: that is cycle 0.
  task automatic do_reset();
    rst = 1'b1;
    ia.req = '0; ia.cmdRank = '0;
    ib.req = '0; ib.cmdRank = '0;
    ic.req = '0; ic.cmdRank = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (ia.winAct !== 1'b0) begin
      errors++; $display("FAIL reset_winAct got %b want 0", ia.winAct);
    end
    checks++;
    if (ia.winPort !== 4'b0000) begin
      errors++; $display("FAIL reset_winPort got %b want 0000", ia.winPort);
    end
    checks++;
    if (ia.rank_blocked !== 4'b0000) begin
      errors++; $display("FAIL reset_rank_blocked got %b want 0000", ia.rank_blocked);
    end
    checks++;
    if (ia.act_winPort_nxt !== 4'b0000) begin
      errors++; $display("FAIL reset_nxt got %b want 0000", ia.act_winPort_nxt);
    end
    checks++;
    if (ia.act_rank_update !== 4'b0000) begin
      errors++; $display("FAIL reset_rank_update got %b want 0000", ia.act_rank_update);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rr_distinct();
    logic [19:0] seq;
    logic [3:0]  prev;
    seq  = {4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    prev = 4'b0000;
    do_reset();
    ia.req     = 4'b1111;
    ia.cmdRank = {2'd3, 2'd2, 2'd1, 2'd0};
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (ia.act_winPort_nxt !== seq[4*c +: 4]) begin
        errors++; $display("FAIL rr_nxt cycle %0d got %b want %b", c, ia.act_winPort_nxt, seq[4*c +: 4]);
      end
      if (c > 0) begin
        checks++;
        if (ia.winPort !== prev) begin
          errors++; $display("FAIL rr_winPort cycle %0d got %b want %b", c, ia.winPort, prev);
        end
        checks++;
        if (ia.winAct !== 1'b1) begin
          errors++; $display("FAIL rr_winAct cycle %0d got %b want 1", c, ia.winAct);
        end
      end
      prev = seq[4*c +: 4];
      @(posedge clk); #1;
    end
  endtask

  // Group 0 on rank 2, TRRD=4: grants at 0,4,...,20, the fifth delayed only by tRRD
  // because cycle 16 is exactly t1+TFAW.
  task automatic test_trrd_faw();
    logic [20:0] mask;
    logic        g;
    mask = 21'h111111;
    do_reset();
    ia.req     = 4'b0001;
    ia.cmdRank = {2'd0, 2'd0, 2'd0, 2'd2};
    for (int c = 0; c <= 20; c++) begin
      g = mask[c];
      #1;
      checks++;
      if (ia.act_winPort_nxt !== (g ? 4'b0001 : 4'b0000)) begin
        errors++; $display("FAIL faw4_nxt cycle %0d got %b want %b", c, ia.act_winPort_nxt, g ? 4'b0001 : 4'b0000);
      end
      checks++;
      if (ia.rank_blocked !== (g ? 4'b0000 : 4'b0100)) begin
        errors++; $display("FAIL faw4_blocked cycle %0d got %b want %b", c, ia.rank_blocked, g ? 4'b0000 : 4'b0100);
      end
      checks++;
      if (ia.act_rank_update !== (g ? 4'b0100 : 4'b0000)) begin
        errors++; $display("FAIL faw4_rank_update cycle %0d got %b want %b", c, ia.act_rank_update, g ? 4'b0100 : 4'b0000);
      end
      if (c > 0) begin
        checks++;
        if (ia.winAct !== mask[c-1]) begin
          errors++; $display("FAIL faw4_winAct cycle %0d got %b want %b", c, ia.winAct, mask[c-1]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // TRRD=2: four grants at 0,2,4,6 fill the window; the fifth waits until 16, then 18.
  task automatic test_trrd2_window();
    logic [18:0] mask;
    logic        g;
    mask = 19'h50055;
    do_reset();
    ib.req     = 4'b0001;
    ib.cmdRank = {2'd0, 2'd0, 2'd0, 2'd2};
    for (int c = 0; c <= 18; c++) begin
      g = mask[c];
      #1;
      checks++;
      if (ib.act_winPort_nxt !== (g ? 4'b0001 : 4'b0000)) begin
        errors++; $display("FAIL faw2_nxt cycle %0d got %b want %b", c, ib.act_winPort_nxt, g ? 4'b0001 : 4'b0000);
      end
      checks++;
      if (ib.rank_blocked !== (g ? 4'b0000 : 4'b0100)) begin
        errors++; $display("FAIL faw2_blocked cycle %0d got %b want %b", c, ib.rank_blocked, g ? 4'b0000 : 4'b0100);
      end
      @(posedge clk); #1;
    end
  endtask

  // All groups on rank 1: one grant every 4 cycles, rotating 0,1,2,3.
  task automatic test_same_rank();
    logic       g;
    logic [3:0] exp_nxt;
    do_reset();
    ia.req     = 4'b1111;
    ia.cmdRank = {2'd1, 2'd1, 2'd1, 2'd1};
    for (int c = 0; c <= 12; c++) begin
      g       = ((c % 4) == 0);
      exp_nxt = g ? (4'b0001 << (c / 4)) : 4'b0000;
      #1;
      checks++;
      if (ia.act_winPort_nxt !== exp_nxt) begin
        errors++; $display("FAIL same_rank_nxt cycle %0d got %b want %b", c, ia.act_winPort_nxt, exp_nxt);
      end
      checks++;
      if (ia.act_rank_update !== (g ? 4'b0010 : 4'b0000)) begin
        errors++; $display("FAIL same_rank_update cycle %0d got %b want %b", c, ia.act_rank_update, g ? 4'b0010 : 4'b0000);
      end
      if (c > 0) begin
        checks++;
        if (ia.winAct !== (((c - 1) % 4) == 0)) begin
          errors++; $display("FAIL same_rank_winAct cycle %0d got %b want %b", c, ia.winAct, ((c - 1) % 4) == 0);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // RANK_SLAB=3: rank code 3 is untracked, so group 3 never wins.
  task automatic test_bad_rank();
    logic [23:0] seq;
    logic        prev_act;
    do_reset();
    ic.req     = 4'b1000;
    ic.cmdRank = {2'd3, 2'd0, 2'd0, 2'd0};
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if (ic.act_winPort_nxt !== 4'b0000) begin
        errors++; $display("FAIL bad_rank_nxt cycle %0d got %b want 0000", c, ic.act_winPort_nxt);
      end
      checks++;
      if (ic.winAct !== 1'b0) begin
        errors++; $display("FAIL bad_rank_winAct cycle %0d got %b want 0", c, ic.winAct);
      end
      @(posedge clk); #1;
    end
    // Groups 0 and 1 (ranks 0 and 1) proceed normally next to the stuck group 3.
    seq        = {4'b0010, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0001};
    prev_act   = 1'b0;
    ic.req     = 4'b1011;
    ic.cmdRank = {2'd3, 2'd0, 2'd1, 2'd0};
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++;
      if (ic.act_winPort_nxt !== seq[4*c +: 4]) begin
        errors++; $display("FAIL mixed_rank_nxt cycle %0d got %b want %b", c, ic.act_winPort_nxt, seq[4*c +: 4]);
      end
      checks++;
      if (ic.winAct !== prev_act) begin
        errors++; $display("FAIL mixed_rank_winAct cycle %0d got %b want %b", c, ic.winAct, prev_act);
      end
      prev_act = |seq[4*c +: 4];
      @(posedge clk); #1;
    end
  endtask

  // TRRD=2 instance: grants 0,2,4,6 leave ptr=1 and rank 0 purely tFAW-blocked at cycle 10.
  task automatic test_reset_mid();
    do_reset();
    ib.req     = 4'b0001;
    ib.cmdRank = {2'd0, 2'd0, 2'd0, 2'd0};
    repeat (10) begin
      @(posedge clk); #1;
    end
    #1;
    checks++;
    if (ib.rank_blocked !== 4'b0001) begin
      errors++; $display("FAIL mid_pre_blocked got %b want 0001", ib.rank_blocked);
    end
    checks++;
    if (ib.act_winPort_nxt !== 4'b0000) begin
      errors++; $display("FAIL mid_pre_nxt got %b want 0000", ib.act_winPort_nxt);
    end
    rst    = 1'b1;
    ib.req = 4'b0011;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (ib.rank_blocked !== 4'b0000) begin
      errors++; $display("FAIL mid_post_blocked got %b want 0000", ib.rank_blocked);
    end
    checks++;
    if (ib.winPort !== 4'b0000) begin
      errors++; $display("FAIL mid_post_winPort got %b want 0000", ib.winPort);
    end
    checks++;
    if (ib.winAct !== 1'b0) begin
      errors++; $display("FAIL mid_post_winAct got %b want 0", ib.winAct);
    end
    // With ptr back at 0, group 0 beats group 1; a stale ptr of 1 would pick group 1.
    checks++;
    if (ib.act_winPort_nxt !== 4'b0001) begin
      errors++; $display("FAIL mid_post_nxt got %b want 0001", ib.act_winPort_nxt);
    end
    checks++;
    if (ib.act_rank_update !== 4'b0001) begin
      errors++; $display("FAIL mid_post_rank_update got %b want 0001", ib.act_rank_update);
    end
    @(posedge clk); #2;
    checks++;
    if (ib.winPort !== 4'b0001) begin
      errors++; $display("FAIL mid_next_winPort got %b want 0001", ib.winPort);
    end
    checks++;
    if (ib.winAct !== 1'b1) begin
      errors++; $display("FAIL mid_next_winAct got %b want 1", ib.winAct);
    end
  endtask

  initial begin
    test_reset();
    test_rr_distinct();
    test_trrd_faw();
    test_trrd2_window();
    test_same_rank();
    test_bad_rank();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
